// File: rtl/glb_bank_arb.sv
// Arbiter for one single-port global-buffer SRAM bank shared by read and write requesters.
// Round-robin within each class, reads over writes, writes forced through after MAX_WAIT denials.
module glb_bank_arb #(
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned SRAM_WORD  = 128,
  parameter int unsigned SRAM_WIDTH = 256,
  parameter int unsigned ADDR_W     = $clog2(SRAM_WORD),
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_RD-1:0]            i_rd_valid,
  input  logic [NUM_RD*ADDR_W-1:0]     i_rd_addr,
  output logic [NUM_RD-1:0]            o_rd_ready,
  output logic [NUM_RD-1:0]            o_rd_rsp_valid,
  output logic [SRAM_WIDTH-1:0]        o_rd_rsp_data,
  input  logic [NUM_WR-1:0]            i_wr_valid,
  input  logic [NUM_WR*ADDR_W-1:0]     i_wr_addr,
  input  logic [NUM_WR*SRAM_WIDTH-1:0] i_wr_data,
  output logic [NUM_WR-1:0]            o_wr_ready,
  output logic                         o_mem_read_en,
  output logic                         o_mem_write_en,
  output logic [ADDR_W-1:0]            o_mem_addr_r,
  output logic [ADDR_W-1:0]            o_mem_addr_w,
  output logic [SRAM_WIDTH-1:0]        o_mem_data_in,
  input  logic [SRAM_WIDTH-1:0]        i_mem_data_out
);

  localparam int unsigned RP_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned WP_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int unsigned WT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WT_W-1:0] WAIT_SAT = WT_W'(MAX_WAIT);
  localparam logic [RP_W-1:0] RP_LAST  = RP_W'(NUM_RD - 1);
  localparam logic [WP_W-1:0] WP_LAST  = WP_W'(NUM_WR - 1);

  logic [RP_W-1:0]   r_rd_ptr;
  logic [WP_W-1:0]   r_wr_ptr;
  logic [WT_W-1:0]   r_wr_wait;
  logic [NUM_RD-1:0] r_rsp_sel;

  logic              w_any_rd;
  logic              w_any_wr;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic [RP_W-1:0]   w_rd_idx;
  logic [WP_W-1:0]   w_wr_idx;
  logic [RP_W-1:0]   w_rd_ptr_nxt;
  logic [WP_W-1:0]   w_wr_ptr_nxt;

  // First valid port at or above ptr, wrapping; result is don't-care when nothing is valid.
  function automatic logic [RP_W-1:0] f_pick_rd(input logic [NUM_RD-1:0] v,
                                                input logic [RP_W-1:0]   ptr);
    logic [NUM_RD-1:0] sh;
    logic              found;
    logic [RP_W-1:0]   res;
    int unsigned       idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      idx = (32'(ptr) + k) % NUM_RD;
      sh  = v >> idx;
      if (!found && sh[0]) begin
        res   = RP_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [WP_W-1:0] f_pick_wr(input logic [NUM_WR-1:0] v,
                                                input logic [WP_W-1:0]   ptr);
    logic [NUM_WR-1:0] sh;
    logic              found;
    logic [WP_W-1:0]   res;
    int unsigned       idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      idx = (32'(ptr) + k) % NUM_WR;
      sh  = v >> idx;
      if (!found && sh[0]) begin
        res   = WP_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_any_rd = |i_rd_valid;
  assign w_any_wr = |i_wr_valid;
  assign w_rd_idx = f_pick_rd(i_rd_valid, r_rd_ptr);
  assign w_wr_idx = f_pick_wr(i_wr_valid, r_wr_ptr);

  // Writes win once they have been denied MAX_WAIT times, or when no read competes.
  assign w_sel_wr = !i_rst && w_any_wr && ((r_wr_wait == WAIT_SAT) || !w_any_rd);
  assign w_sel_rd = !i_rst && w_any_rd && !w_sel_wr;

  assign w_rd_ptr_nxt = (w_rd_idx == RP_LAST) ? '0 : w_rd_idx + 1'b1;
  assign w_wr_ptr_nxt = (w_wr_idx == WP_LAST) ? '0 : w_wr_idx + 1'b1;

  always_comb begin
    o_rd_ready     = '0;
    o_wr_ready     = '0;
    o_mem_read_en  = w_sel_rd;
    o_mem_write_en = w_sel_wr;
    o_mem_addr_r   = '0;
    o_mem_addr_w   = '0;
    o_mem_data_in  = '0;
    if (w_sel_rd) begin
      o_rd_ready   = NUM_RD'(1) << w_rd_idx;
      o_mem_addr_r = ADDR_W'(i_rd_addr >> (ADDR_W * 32'(w_rd_idx)));
    end
    if (w_sel_wr) begin
      o_wr_ready    = NUM_WR'(1) << w_wr_idx;
      o_mem_addr_w  = ADDR_W'(i_wr_addr >> (ADDR_W * 32'(w_wr_idx)));
      o_mem_data_in = SRAM_WIDTH'(i_wr_data >> (SRAM_WIDTH * 32'(w_wr_idx)));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_wr_wait <= '0;
      r_rsp_sel <= '0;
    end else begin
      if (w_sel_rd) r_rd_ptr <= w_rd_ptr_nxt;
      if (w_sel_wr) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_sel_wr || !w_any_wr) begin
        r_wr_wait <= '0;
      end else if (w_sel_rd && (r_wr_wait != WAIT_SAT)) begin
        r_wr_wait <= r_wr_wait + 1'b1;
      end
      r_rsp_sel <= o_rd_ready;
    end
  end

  // Masking with reset drops an in-flight response immediately.
  assign o_rd_rsp_valid = r_rsp_sel & ~{NUM_RD{i_rst}};
  assign o_rd_rsp_data  = i_mem_data_out;

endmodule

// File: tb/tb_glb_bank_arb.sv
// Self-checking bench for glb_bank_arb: directed scenarios plus randomized traffic against
// a behavioural model of grant order, starvation bound and one-cycle read responses.
module tb_glb_bank_arb;
  localparam int NR    = 3;
  localparam int NW    = 2;
  localparam int WORDS = 128;
  localparam int WID   = 256;
  localparam int AW    = 7;
  localparam int MW    = 4;
  localparam int RAW   = NR * AW;
  localparam int WAW   = NW * AW;
  localparam int WWD   = NW * WID;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]  rd_valid;
  logic [RAW-1:0] rd_addr;
  logic [NR-1:0]  rd_ready;
  logic [NR-1:0]  rd_rsp_valid;
  logic [WID-1:0] rd_rsp_data;
  logic [NW-1:0]  wr_valid;
  logic [WAW-1:0] wr_addr;
  logic [WWD-1:0] wr_data;
  logic [NW-1:0]  wr_ready;
  logic           mem_re, mem_we;
  logic [AW-1:0]  mem_addr_r, mem_addr_w;
  logic [WID-1:0] mem_din;
  logic [WID-1:0] mem_dout = '0;

  always #5 clk = ~clk;

  glb_bank_arb #(
    .NUM_RD(NR), .NUM_WR(NW), .SRAM_WORD(WORDS), .SRAM_WIDTH(WID), .ADDR_W(AW), .MAX_WAIT(MW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
    .o_rd_rsp_valid(rd_rsp_valid), .o_rd_rsp_data(rd_rsp_data),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_mem_read_en(mem_re), .o_mem_write_en(mem_we),
    .o_mem_addr_r(mem_addr_r), .o_mem_addr_w(mem_addr_w),
    .o_mem_data_in(mem_din), .i_mem_data_out(mem_dout)
  );

  // Bank model: one access per cycle, one-cycle read latency.
  logic [WID-1:0] ram [WORDS] = '{default: '0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr_w] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_addr_r];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int             m_rd_ptr = 0, m_wr_ptr = 0, m_wr_wait = 0, m_pend = -1;
  logic [WID-1:0] m_pend_data = '0;
  logic [WID-1:0] sh_mem [WORDS] = '{default: '0};

  logic [NR-1:0]  e_rd_ready, e_rsp_valid;
  logic [NW-1:0]  e_wr_ready;
  logic           e_re, e_we;
  logic [AW-1:0]  e_addr_r, e_addr_w;
  logic [WID-1:0] e_din, e_rsp_data;
  int             e_rd_idx, e_wr_idx;

  task automatic model_eval();
    e_rd_ready = '0; e_wr_ready = '0; e_re = 1'b0; e_we = 1'b0;
    e_addr_r = '0; e_addr_w = '0; e_din = '0;
    e_rd_idx = -1; e_wr_idx = -1;
    e_rsp_valid = (!rst && m_pend >= 0) ? (NR'(1) << m_pend) : '0;
    e_rsp_data  = m_pend_data;
    if (!rst) begin
      if (wr_valid != 0 && (m_wr_wait == MW || rd_valid == 0)) begin
        for (int k = 0; k < NW; k++) begin
          int p;
          p = (m_wr_ptr + k) % NW;
          if (e_wr_idx < 0 && ((wr_valid >> p) & 1) != 0) e_wr_idx = p;
        end
      end else if (rd_valid != 0) begin
        for (int k = 0; k < NR; k++) begin
          int p;
          p = (m_rd_ptr + k) % NR;
          if (e_rd_idx < 0 && ((rd_valid >> p) & 1) != 0) e_rd_idx = p;
        end
      end
    end
    if (e_rd_idx >= 0) begin
      e_rd_ready = NR'(1) << e_rd_idx;
      e_re       = 1'b1;
      e_addr_r   = AW'(rd_addr >> (e_rd_idx * AW));
    end
    if (e_wr_idx >= 0) begin
      e_wr_ready = NW'(1) << e_wr_idx;
      e_we       = 1'b1;
      e_addr_w   = AW'(wr_addr >> (e_wr_idx * AW));
      e_din      = WID'(wr_data >> (e_wr_idx * WID));
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_rd_ptr = 0; m_wr_ptr = 0; m_wr_wait = 0; m_pend = -1;
    end else begin
      m_pend = e_rd_idx;
      if (e_rd_idx >= 0) begin
        m_pend_data = sh_mem[e_addr_r];
        m_rd_ptr    = (e_rd_idx + 1) % NR;
      end
      if (e_wr_idx >= 0) begin
        sh_mem[e_addr_w] = e_din;
        m_wr_ptr         = (e_wr_idx + 1) % NW;
      end
      if (e_wr_idx >= 0 || wr_valid == 0) m_wr_wait = 0;
      else if (e_rd_idx >= 0 && m_wr_wait < MW) m_wr_wait++;
    end
  endtask

  task automatic eval_cycle();
    #1;
    model_eval();
  endtask

  task automatic end_cycle();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_valid = '0; wr_valid = '0;
    eval_cycle();
    end_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_valid = NR'($urandom); wr_valid = NW'($urandom);
      rd_addr = RAW'($urandom); wr_addr = WAW'($urandom); wr_data = {16{$urandom}};
      eval_cycle();
      n_cmp++; if (rd_ready !== '0) begin n_bad++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
      n_cmp++; if (wr_ready !== '0) begin n_bad++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
      n_cmp++; if (rd_rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rd_rsp_valid); end
      n_cmp++; if ({mem_re, mem_we} !== 2'b00) begin n_bad++; $display("FAIL reset_en got %b%b want 00", mem_re, mem_we); end
      n_cmp++; if (mem_addr_r !== '0 || mem_addr_w !== '0) begin n_bad++; $display("FAIL reset_addr got %h/%h want 0/0", mem_addr_r, mem_addr_w); end
      n_cmp++; if (mem_din !== '0) begin n_bad++; $display("FAIL reset_data_in got %h want 0", mem_din); end
      end_cycle();
    end
    rst = 1'b0; rd_valid = '0; wr_valid = '0;
  endtask

  task automatic test_single_read();
    logic [WID-1:0] pat;
    pat = {32{8'hA5}};
    wr_valid = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {WID'(0), pat}; rd_valid = '0;
    eval_cycle();
    n_cmp++; if (wr_ready !== 2'b01 || mem_we !== 1'b1 || mem_re !== 1'b0) begin n_bad++; $display("FAIL sr_write_grant got rdy=%b we=%b re=%b want 01/1/0", wr_ready, mem_we, mem_re); end
    n_cmp++; if (mem_addr_w !== AW'(5) || mem_din !== pat) begin n_bad++; $display("FAIL sr_write_bus got a=%0d d=%h want 5/%h", mem_addr_w, mem_din, pat); end
    end_cycle();
    wr_valid = '0; rd_valid = 3'b010; rd_addr = {AW'(0), AW'(5), AW'(0)};
    eval_cycle();
    n_cmp++; if (rd_ready !== 3'b010 || mem_re !== 1'b1 || mem_addr_r !== AW'(5)) begin n_bad++; $display("FAIL sr_read_grant got rdy=%b re=%b a=%0d want 010/1/5", rd_ready, mem_re, mem_addr_r); end
    end_cycle();
    rd_valid = '0;
    eval_cycle();
    n_cmp++; if (rd_rsp_valid !== 3'b010) begin n_bad++; $display("FAIL sr_rsp_valid got %b want 010", rd_rsp_valid); end
    n_cmp++; if (rd_rsp_data !== pat) begin n_bad++; $display("FAIL sr_rsp_data got %h want %h", rd_rsp_data, pat); end
    end_cycle();
  endtask

  task automatic test_rotate();
    logic [NR-1:0] exp_g, exp_v;
    do_reset();
    rd_valid = 3'b111; wr_valid = '0; rd_addr = {AW'(9), AW'(5), AW'(3)};
    for (int i = 0; i < 6; i++) begin
      eval_cycle();
      exp_g = NR'(1) << (i % 3);
      exp_v = (i == 0) ? '0 : (NR'(1) << ((i - 1) % 3));
      n_cmp++; if (rd_ready !== exp_g) begin n_bad++; $display("FAIL rot_grant[%0d] got %b want %b", i, rd_ready, exp_g); end
      n_cmp++; if (rd_rsp_valid !== exp_v) begin n_bad++; $display("FAIL rot_rsp[%0d] got %b want %b", i, rd_rsp_valid, exp_v); end
      if (i > 0) begin
        n_cmp++; if (rd_rsp_data !== e_rsp_data) begin n_bad++; $display("FAIL rot_data[%0d] got %h want %h", i, rd_rsp_data, e_rsp_data); end
      end
      end_cycle();
    end
  endtask

  task automatic test_starvation();
    int nrd;
    logic [NR-1:0] exp_g;
    do_reset();
    nrd = 0;
    rd_valid = 3'b111; rd_addr = {AW'(1), AW'(2), AW'(3)};
    wr_valid = 2'b01; wr_addr = {AW'(0), AW'(40)}; wr_data = {16{$urandom}};
    for (int c = 0; c < 10; c++) begin
      eval_cycle();
      if (c % 5 == 4) begin
        n_cmp++; if (wr_ready !== 2'b01 || mem_we !== 1'b1 || mem_re !== 1'b0 || rd_ready !== '0) begin n_bad++; $display("FAIL starve_write[%0d] got wr=%b we=%b re=%b rd=%b want 01/1/0/000", c, wr_ready, mem_we, mem_re, rd_ready); end
      end else begin
        exp_g = NR'(1) << (nrd % 3);
        nrd++;
        n_cmp++; if (rd_ready !== exp_g || wr_ready !== '0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL starve_read[%0d] got rd=%b wr=%b we=%b want %b/00/0", c, rd_ready, wr_ready, mem_we, exp_g); end
      end
      end_cycle();
    end
  endtask

  task automatic test_wr_alternate();
    logic [NW-1:0] exp_g;
    logic [WID-1:0] d0, d1, exp_d;
    do_reset();
    d0 = {8{$urandom}}; d1 = {8{$urandom}};
    rd_valid = '0; wr_valid = 2'b11; wr_addr = {AW'(20), AW'(21)}; wr_data = {d1, d0};
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      exp_g = NW'(1) << (i % 2);
      exp_d = (i % 2 == 0) ? d0 : d1;
      n_cmp++; if (wr_ready !== exp_g || mem_re !== 1'b0) begin n_bad++; $display("FAIL walt_grant[%0d] got %b re=%b want %b re=0", i, wr_ready, mem_re, exp_g); end
      n_cmp++; if (mem_din !== exp_d) begin n_bad++; $display("FAIL walt_data[%0d] got %h want %h", i, mem_din, exp_d); end
      end_cycle();
    end
    wr_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rd_valid = 3'b100; wr_valid = '0; rd_addr = {AW'(7), AW'(8), AW'(9)};
    eval_cycle();
    n_cmp++; if (rd_ready !== 3'b100) begin n_bad++; $display("FAIL rm_grant got %b want 100", rd_ready); end
    end_cycle();
    rst = 1'b1; rd_valid = 3'b110;
    eval_cycle();
    n_cmp++; if (rd_rsp_valid !== '0 || rd_ready !== '0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rm_during got rsp=%b rdy=%b re=%b we=%b want all 0", rd_rsp_valid, rd_ready, mem_re, mem_we); end
    end_cycle();
    rst = 1'b0;
    eval_cycle();
    n_cmp++; if (rd_ready !== 3'b010 || rd_rsp_valid !== '0) begin n_bad++; $display("FAIL rm_after got rdy=%b rsp=%b want 010/000", rd_ready, rd_rsp_valid); end
    end_cycle();
    rd_valid = '0;
    eval_cycle();
    n_cmp++; if (rd_rsp_valid !== 3'b010) begin n_bad++; $display("FAIL rm_rsp got %b want 010", rd_rsp_valid); end
    end_cycle();
  endtask

  task automatic test_random();
    logic [NR-1:0] g_rd;
    logic [NW-1:0] g_wr;
    int density, starve;
    do_reset();
    g_rd = '0; g_wr = '0; starve = 0; density = 50;
    rd_valid = '0; wr_valid = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 500 == 0) density = (cyc % 1500 == 0) ? 20 : ((cyc % 1000 == 0) ? 90 : 55);
      rst = ($urandom_range(0, 799) == 0);
      for (int k = 0; k < NR; k++) begin
        if (((g_rd >> k) & 1) != 0) rd_valid = rd_valid & ~(NR'(1) << k);
        if (((rd_valid >> k) & 1) == 0 && $urandom_range(0, 99) < density) begin
          rd_valid = rd_valid | (NR'(1) << k);
          rd_addr  = (rd_addr & ~(RAW'({AW{1'b1}}) << (k * AW)))
                   | (RAW'($urandom_range(0, 15)) << (k * AW));
        end
      end
      for (int k = 0; k < NW; k++) begin
        if (((g_wr >> k) & 1) != 0) wr_valid = wr_valid & ~(NW'(1) << k);
        if (((wr_valid >> k) & 1) == 0 && $urandom_range(0, 99) < density / 2) begin
          wr_valid = wr_valid | (NW'(1) << k);
          wr_addr  = (wr_addr & ~(WAW'({AW{1'b1}}) << (k * AW)))
                   | (WAW'($urandom_range(0, 15)) << (k * AW));
          wr_data  = (wr_data & ~({WWD{1'b0}} | (WWD'({WID{1'b1}}) << (k * WID))))
                   | (WWD'({8{$urandom}}) << (k * WID));
        end
      end
      eval_cycle();
      n_cmp++; if (rd_ready !== e_rd_ready || wr_ready !== e_wr_ready) begin n_bad++; $display("FAIL rnd_grant[%0d] got rd=%b wr=%b want rd=%b wr=%b", cyc, rd_ready, wr_ready, e_rd_ready, e_wr_ready); end
      n_cmp++; if (mem_re !== e_re || mem_we !== e_we) begin n_bad++; $display("FAIL rnd_en[%0d] got re=%b we=%b want re=%b we=%b", cyc, mem_re, mem_we, e_re, e_we); end
      n_cmp++; if (mem_addr_r !== e_addr_r || mem_addr_w !== e_addr_w) begin n_bad++; $display("FAIL rnd_addr[%0d] got r=%0d w=%0d want r=%0d w=%0d", cyc, mem_addr_r, mem_addr_w, e_addr_r, e_addr_w); end
      n_cmp++; if (mem_din !== e_din) begin n_bad++; $display("FAIL rnd_din[%0d] got %h want %h", cyc, mem_din, e_din); end
      n_cmp++; if (rd_rsp_valid !== e_rsp_valid) begin n_bad++; $display("FAIL rnd_rsp_valid[%0d] got %b want %b", cyc, rd_rsp_valid, e_rsp_valid); end
      if (e_rsp_valid != 0) begin
        n_cmp++; if (rd_rsp_data !== e_rsp_data) begin n_bad++; $display("FAIL rnd_rsp_data[%0d] got %h want %h", cyc, rd_rsp_data, e_rsp_data); end
      end
      n_cmp++; if ((mem_re && mem_we) || !$onehot0(rd_ready) || !$onehot0(wr_ready)) begin n_bad++; $display("FAIL rnd_exclusive[%0d] got re=%b we=%b rd=%b wr=%b want at most one", cyc, mem_re, mem_we, rd_ready, wr_ready); end
      if (rst || wr_ready != 0 || wr_valid == 0) starve = 0;
      else if (rd_ready != 0) starve++;
      n_cmp++; if (starve > MW) begin n_bad++; $display("FAIL rnd_starve[%0d] got %0d denials want <= %0d", cyc, starve, MW); end
      g_rd = rd_ready; g_wr = wr_ready;
      end_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_valid = '0; wr_valid = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_rotate();
    test_starvation();
    test_wr_alternate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
